// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one pipelined single-port RAM (1-cycle read latency)
// between an instruction-fetch requester (port 0) and a load/store
// requester (port 1).
//
// Handshake: a requester raises pN_valid_i with a stable payload. The
// request is accepted in the same cycle that pN_ready_o is 1. The requester
// may drop valid without being granted. Every accepted access, read or
// write, gets exactly one pN_resp_o pulse in the next cycle. On a read,
// pN_data_o carries the data in that cycle. An access accepted in the cycle
// before a reset gets no response.
module spram_arbiter #(
  parameter int SIZE  = 1024,
  parameter int DATAW = 32,
  parameter int RR_EN = 1,
  parameter int ADDRW = $clog2(SIZE),
  parameter int MASKW = DATAW / 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // port 0: instruction fetch
  input  logic             p0_valid_i,
  output logic             p0_ready_o,
  input  logic [ADDRW-1:0] p0_addr_i,
  input  logic [DATAW-1:0] p0_data_i,
  input  logic [MASKW-1:0] p0_mask_i,
  input  logic             p0_we_i,
  output logic             p0_resp_o,
  output logic [DATAW-1:0] p0_data_o,
  // port 1: load/store
  input  logic             p1_valid_i,
  output logic             p1_ready_o,
  input  logic [ADDRW-1:0] p1_addr_i,
  input  logic [DATAW-1:0] p1_data_i,
  input  logic [MASKW-1:0] p1_mask_i,
  input  logic             p1_we_i,
  output logic             p1_resp_o,
  output logic [DATAW-1:0] p1_data_o,
  // RAM side
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [DATAW-1:0] mem_data_o,
  output logic [MASKW-1:0] mem_mask_o,
  output logic             mem_we_o,
  output logic             mem_valid_o,
  input  logic [DATAW-1:0] mem_data_i,
  input  logic             mem_resp_i
);

  // Grant of the current cycle. At most one of these is set.
  logic gnt0;
  logic gnt1;

  // last_grant: port number of the most recently accepted request.
  // owner/inflight form a one-entry scoreboard for the RAM access that is
  // currently in flight.
  logic last_grant_q;
  logic last_grant_d;
  logic owner_q;
  logic owner_d;
  logic inflight_q;
  logic inflight_d;

  // Arbitration: combinational from the valid inputs and last_grant. It is
  // suppressed while reset is asserted, so no access is accepted then.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      if (p0_valid_i && p1_valid_i) begin
        if (RR_EN != 0) begin
          // Contention: the port that was not granted last wins.
          gnt0 = last_grant_q;
          gnt1 = ~last_grant_q;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = p0_valid_i;
        gnt1 = p1_valid_i;
      end
    end
  end

  assign p0_ready_o = gnt0;
  assign p1_ready_o = gnt1;

  // RAM request mux: the granted port drives the RAM. When there is no
  // grant, only valid and we are forced low. The other fields follow port 0.
  always_comb begin
    mem_valid_o = gnt0 | gnt1;
    mem_we_o    = 1'b0;
    mem_addr_o  = p0_addr_i;
    mem_data_o  = p0_data_i;
    mem_mask_o  = p0_mask_i;
    if (gnt1) begin
      mem_we_o   = p1_we_i;
      mem_addr_o = p1_addr_i;
      mem_data_o = p1_data_i;
      mem_mask_o = p1_mask_i;
    end else if (gnt0) begin
      mem_we_o = p0_we_i;
    end
  end

  // Scoreboard next state: record who owns the access issued this cycle.
  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    inflight_d   = gnt0 | gnt1;
    if (gnt0) begin
      last_grant_d = 1'b0;
      owner_d      = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
      owner_d      = 1'b1;
    end
  end

  // Scoreboard registers. Reset leaves last_grant at port 1 so that port 0
  // wins the first contention after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      inflight_q   <= inflight_d;
    end
  end

  // Response routing. A RAM response is forwarded only when an access is
  // in flight. It is dropped while reset is asserted, so an access accepted
  // just before a reset never completes.
  assign p0_resp_o = mem_resp_i & inflight_q & ~owner_q & ~rst_i;
  assign p1_resp_o = mem_resp_i & inflight_q &  owner_q & ~rst_i;
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;

endmodule
